sat_add_arbiter: RTL and testbench
==================================

SAT_ADD_ARBITER -- requirements
Module: sat_add_arbiter

Interface
REQ-001 The block SHALL be clocked by one clock and reset by an asynchronous, active-low reset: clk, rst_n.
REQ-002 Ports SHALL be, one per line: name direction width meaning:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_vld  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  4 each  requester 0 signed operands
- req0_rdy  output  1  requester 0 pair accepted this cycle
- req1_vld, req1_a, req1_b, req1_rdy  same as requester 0, for requester 1
- res_vld  output  1  result register holds a valid result
- res_sum  output  4  saturated signed sum
- res_sat  output  1  saturation occurred for this result
- res_id  output  1  requester that owns the result
- res_rdy  input  1  consumer accepts the result
- sat_cnt  output  8  total saturation events since reset or clear
- sat_cnt_clr  input  1  synchronous clear of sat_cnt

Function
REQ-003 The block SHALL share one 4-bit signed saturating adder between two requesters with valid/ready handshakes.
REQ-004 A transfer SHALL occur on a requester port when vld and rdy are both 1 at a rising clk edge.
REQ-005 Define out_free = !res_vld || res_rdy; no requester SHALL be granted when out_free is 0.
REQ-006 Grant SHALL be round-robin: if only one vld is set, that requester is granted; if both are set, the requester not served in the last accepted transfer is granted.
REQ-007 After reset, requester 0 SHALL win the first tie.
REQ-008 reqN_rdy SHALL be combinational: out_free AND grant==N; at most one rdy SHALL be 1 per cycle.
REQ-009 The round-robin pointer SHALL update only on an accepted transfer, and not on cycles without a grant or on stalled cycles.
REQ-010 Latency SHALL be 1 cycle: the result of a pair accepted at edge k appears on res_* after edge k with res_vld=1.
REQ-011 Saturation rules:
- Both operands non-negative with a wrapped sum that is negative gives res_sum=0111, res_sat=1.
- Both operands negative with a wrapped sum that is non-negative gives res_sum=1000, res_sat=1.
- Otherwise res_sum is the 4-bit two's-complement sum and res_sat=0.
REQ-012 While res_vld=1 and res_rdy=0, res_sum, res_sat and res_id SHALL hold stable.
REQ-013 A result consumed at the same edge as a new acceptance SHALL be replaced by the new result, giving full throughput of 1 result per cycle.
REQ-014 If res_vld=1, res_rdy=1 and nothing is accepted, res_vld SHALL go to 0.
REQ-015 sat_cnt SHALL increment by 1 on each accepted transfer whose result saturates.
REQ-016 sat_cnt SHALL stick at 255 and SHALL NOT wrap.
REQ-017 sat_cnt_clr SHALL force sat_cnt to 0 and SHALL take priority over a simultaneous increment.
REQ-018 A requester's vld SHALL NOT be required to stay high without a grant; the arbiter SHALL tolerate vld dropping.

Reset
REQ-019 On rst_n=0, asynchronously: res_vld=0, res_sum=0000, res_sat=0, res_id=0, sat_cnt=0, round-robin pointer set so that requester 0 wins the next tie.
REQ-020 Reset mid-operation SHALL discard any held result without delivering it.
REQ-021 With rst_n=0, both rdy outputs SHALL be 0.

Structure
REQ-022 A shared package sat_add_pkg SHALL hold the constants W=4, SAT_MAX=4'b0111, SAT_MIN=4'b1000 and CNT_W=8.
REQ-023 The existing signed_add_with_saturation module SHALL be instantiated once as the only sub-module.
REQ-024 res_sat SHALL be derived by comparing the saturated sum with the wrapped sum a+b.

Verification
REQ-025 The bench SHALL cover:
- Single requester 0, a=0011, b=0100, res_rdy=1: next cycle res_sum=0111, res_sat=0, res_id=0.
- Requester 1, a=0101, b=0100: res_sum=0111, res_sat=1, sat_cnt=1.
- Requester 0, a=1000, b=1111: res_sum=1000, res_sat=1.
- Requester 0, a=1110, b=0011: res_sum=0001, res_sat=0.
- Both vld held high for 6 cycles, res_rdy=1: res_id sequence 0,1,0,1,0,1, one result per cycle.
- res_rdy=0 for 3 cycles with both vld high: both rdy=0, res_* stable; on res_rdy=1 the next grant follows round-robin order.
- 300 saturating transfers: sat_cnt=255.
- Assert sat_cnt_clr together with a saturating transfer: sat_cnt=0.
- Assert rst_n=0 while res_vld=1: res_vld=0 immediately, and requester 0 wins the first tie after release.

Source files
------------

// File: rtl/sat_add_pkg.sv
// Shared constants and types for the saturating-adder arbiter.
// Imported by every file of this block.
package sat_add_pkg;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    localparam logic [W-1:0] SAT_MAX = 4'b0111;
    localparam logic [W-1:0] SAT_MIN = 4'b1000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         sat;
        logic         id;
    } res_t;

endpackage

// File: rtl/sat_add_arbiter_if.sv
// Bundle of requester/consumer handshakes around sat_add_arbiter.
// master = requesters and consumer, slave = the arbiter.
interface sat_add_arbiter_if;
    import sat_add_pkg::*;

    logic             req0_vld;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_rdy;
    logic             req1_vld;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_rdy;
    logic             res_vld;
    logic [W-1:0]     res_sum;
    logic             res_sat;
    logic             res_id;
    logic             res_rdy;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_cnt_clr;

    modport master (
        output req0_vld, req0_a, req0_b,
        output req1_vld, req1_a, req1_b,
        output res_rdy, sat_cnt_clr,
        input  req0_rdy, req1_rdy,
        input  res_vld, res_sum, res_sat, res_id,
        input  sat_cnt
    );

    modport slave (
        input  req0_vld, req0_a, req0_b,
        input  req1_vld, req1_a, req1_b,
        input  res_rdy, sat_cnt_clr,
        output req0_rdy, req1_rdy,
        output res_vld, res_sum, res_sat, res_id,
        output sat_cnt
    );

endinterface

// File: rtl/signed_add_with_saturation.sv
// Combinational W-bit two's-complement adder clamping to SAT_MAX/SAT_MIN.
module signed_add_with_saturation
    import sat_add_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] wrap;
    logic         pos_ovf;
    logic         neg_ovf;

    assign wrap    = a + b;
    assign pos_ovf = !a[W-1] && !b[W-1] && wrap[W-1];
    assign neg_ovf = a[W-1] && b[W-1] && !wrap[W-1];

    always_comb begin
        sum = wrap;
        unique case (1'b1)
            pos_ovf: sum = SAT_MAX;
            neg_ovf: sum = SAT_MIN;
            default: sum = wrap;
        endcase
    end

endmodule

// File: rtl/sat_add_arbiter.sv
// Two requesters share one saturating adder; round-robin grant,
// one-cycle registered result and a sticky saturation counter.
module sat_add_arbiter
    import sat_add_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_vld,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_rdy,
    output logic             res_vld,
    output logic [W-1:0]     res_sum,
    output logic             res_sat,
    output logic             res_id,
    input  logic             res_rdy,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_cnt_clr
);

    logic         out_free;
    logic         gnt0;
    logic         gnt1;
    logic         take;
    logic         last_id;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] sum_wrap;
    logic [W-1:0] sum_sat;
    logic         sat_hit;
    logic         vld_q;
    res_t         res_q;
    logic [CNT_W-1:0] cnt_q;

    assign out_free = !vld_q || res_rdy;

    // On a tie the requester not served last wins; last_id resets to 1.
    always_comb begin
        gnt0 = req0_vld && (!req1_vld || last_id);
        gnt1 = req1_vld && (!req0_vld || !last_id);
    end

    assign req0_rdy = rst_n && out_free && gnt0;
    assign req1_rdy = rst_n && out_free && gnt1;
    assign take     = req0_rdy || req1_rdy;

    assign op_a = gnt1 ? req1_a : req0_a;
    assign op_b = gnt1 ? req1_b : req0_b;

    signed_add_with_saturation u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum_sat)
    );

    assign sum_wrap = op_a + op_b;
    assign sat_hit  = sum_sat != sum_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            res_q   <= '0;
            last_id <= 1'b1;
        end else if (take) begin
            vld_q     <= 1'b1;
            res_q.sum <= sum_sat;
            res_q.sat <= sat_hit;
            res_q.id  <= gnt1;
            last_id   <= gnt1;
        end else if (res_rdy) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (sat_cnt_clr) begin
            cnt_q <= '0;
        end else if (take && sat_hit && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign res_vld = vld_q;
    assign res_sum = res_q.sum;
    assign res_sat = res_q.sat;
    assign res_id  = res_q.id;
    assign sat_cnt = cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter with a per-cycle reference model.
module tb_sat_add_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sat_add_arbiter_if bus ();

    sat_add_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_vld    (bus.req0_vld),
        .req0_a      (bus.req0_a),
        .req0_b      (bus.req0_b),
        .req0_rdy    (bus.req0_rdy),
        .req1_vld    (bus.req1_vld),
        .req1_a      (bus.req1_a),
        .req1_b      (bus.req1_b),
        .req1_rdy    (bus.req1_rdy),
        .res_vld     (bus.res_vld),
        .res_sum     (bus.res_sum),
        .res_sat     (bus.res_sat),
        .res_id      (bus.res_id),
        .res_rdy     (bus.res_rdy),
        .sat_cnt     (bus.sat_cnt),
        .sat_cnt_clr (bus.sat_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: integer sum clamped to [-8,7], round-robin by last served.
    bit m_vld;
    int m_sum;
    bit m_sat;
    int m_id;
    int m_last;
    int m_cnt;
    bit e_free;
    bit e_g0;
    bit e_g1;
    int e_raw;
    int e_s;

    always @* begin
        e_free = !m_vld || bus.res_rdy;
        e_g0   = 1'b0;
        e_g1   = 1'b0;
        if (bus.req0_vld && bus.req1_vld) begin
            if (m_last == 0) e_g1 = 1'b1;
            else             e_g0 = 1'b1;
        end else begin
            e_g0 = bus.req0_vld;
            e_g1 = bus.req1_vld;
        end
        e_g0 = e_g0 && e_free;
        e_g1 = e_g1 && e_free;
        if (e_g1)
            e_raw = int'($signed(bus.req1_a)) + int'($signed(bus.req1_b));
        else
            e_raw = int'($signed(bus.req0_a)) + int'($signed(bus.req0_b));
        e_s = e_raw > 7 ? 7 : (e_raw < -8 ? -8 : e_raw);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_sum  <= 0;
            m_sat  <= 1'b0;
            m_id   <= 0;
            m_last <= 1;
            m_cnt  <= 0;
        end else begin
            if (e_g0 || e_g1) begin
                m_vld  <= 1'b1;
                m_sum  <= e_s;
                m_sat  <= e_raw != e_s;
                m_id   <= e_g1 ? 1 : 0;
                m_last <= e_g1 ? 1 : 0;
            end else if (bus.res_rdy) begin
                m_vld <= 1'b0;
            end
            if (bus.sat_cnt_clr)
                m_cnt <= 0;
            else if ((e_g0 || e_g1) && e_raw != e_s && m_cnt < 255)
                m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_rdy0", int'(bus.req0_rdy), int'(e_g0));
            chk("m_rdy1", int'(bus.req1_rdy), int'(e_g1));
            chk("m_vld", int'(bus.res_vld), int'(m_vld));
            chk("m_cnt", int'(bus.sat_cnt), m_cnt);
            if (m_vld) begin
                chk("m_sum", int'($signed(bus.res_sum)), m_sum);
                chk("m_sat", int'(bus.res_sat), int'(m_sat));
                chk("m_id", int'(bus.res_id), m_id);
            end
        end
    end

    task automatic idle();
        bus.req0_vld    = 1'b0;
        bus.req1_vld    = 1'b0;
        bus.req0_a      = '0;
        bus.req0_b      = '0;
        bus.req1_a      = '0;
        bus.req1_b      = '0;
        bus.sat_cnt_clr = 1'b0;
    endtask

    // One lone transfer with res_rdy=1; returns just after the accepting edge.
    task automatic one(input int id, input logic [3:0] a, input logic [3:0] b);
        bus.res_rdy = 1'b1;
        if (id == 0) begin
            bus.req0_vld = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_vld = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
        @(posedge clk); #1;
        idle();
    endtask

    int sum0;
    int id0;

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus.res_rdy = 1'b1;
        rst_n = 1'b0;
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        #3;
        chk("rst_rdy0", int'(bus.req0_rdy), 0);
        chk("rst_rdy1", int'(bus.req1_rdy), 0);
        chk("rst_vld", int'(bus.res_vld), 0);
        chk("rst_sum", int'(bus.res_sum), 0);
        chk("rst_sat", int'(bus.res_sat), 0);
        chk("rst_id", int'(bus.res_id), 0);
        chk("rst_cnt", int'(bus.sat_cnt), 0);
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        one(0, 4'b0011, 4'b0100);
        chk("v1_sum", int'(bus.res_sum), 4'b0111);
        chk("v1_sat", int'(bus.res_sat), 0);
        chk("v1_id", int'(bus.res_id), 0);
        one(1, 4'b0101, 4'b0100);
        chk("v2_sum", int'(bus.res_sum), 4'b0111);
        chk("v2_sat", int'(bus.res_sat), 1);
        chk("v2_cnt", int'(bus.sat_cnt), 1);
        one(0, 4'b1000, 4'b1111);
        chk("v3_sum", int'(bus.res_sum), 4'b1000);
        chk("v3_sat", int'(bus.res_sat), 1);
        one(0, 4'b1110, 4'b0011);
        chk("v4_sum", int'(bus.res_sum), 4'b0001);
        chk("v4_sat", int'(bus.res_sat), 0);
        one(1, 4'b0001, 4'b0001);
        chk("v5_sum", int'(bus.res_sum), 4'b0010);

        // Tie for 6 cycles; last served was requester 1.
        bus.req0_vld = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req1_vld = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rr_id", int'(bus.res_id), i % 2);
            chk("rr_vld", int'(bus.res_vld), 1);
        end

        // Stall: held result is requester 1 (sum 4).
        bus.res_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_rdy0", int'(bus.req0_rdy), 0);
            chk("st_rdy1", int'(bus.req1_rdy), 0);
            @(posedge clk); #1;
            chk("st_id", int'(bus.res_id), 1);
            chk("st_sum", int'(bus.res_sum), 4);
        end
        bus.res_rdy = 1'b1;
        @(posedge clk); #1;
        chk("st_next_id", int'(bus.res_id), 0);
        chk("st_next_sum", int'(bus.res_sum), 2);
        idle();

        bus.req0_vld = 1'b1; bus.req0_a = 4'd7; bus.req0_b = 4'd7;
        repeat (300) @(posedge clk);
        #1;
        chk("cnt_stick", int'(bus.sat_cnt), 255);
        bus.sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        chk("cnt_clr", int'(bus.sat_cnt), 0);
        chk("clr_sat", int'(bus.res_sat), 1);
        idle();

        // Hold a requester-0 result, then reset mid-cycle.
        bus.res_rdy = 1'b0;
        bus.req0_vld = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd3;
        @(posedge clk); #1;
        idle();
        chk("pre_rst_vld", int'(bus.res_vld), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld", int'(bus.res_vld), 0);
        chk("arst_cnt", int'(bus.sat_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.res_rdy = 1'b1;
        bus.req0_vld = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd0;
        bus.req1_vld = 1'b1; bus.req1_a = 4'd3; bus.req1_b = 4'd0;
        @(posedge clk); #1;
        sum0 = int'(bus.res_sum);
        id0  = int'(bus.res_id);
        chk("post_rst_id", id0, 0);
        chk("post_rst_sum", sum0, 1);
        idle();
        @(posedge clk); #1;
        chk("drain_vld", int'(bus.res_vld), 0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
